image_writer: RTL

- Avalon-MM slave that receives a 224x224 8-bit luma image from the HPS and buffers it in on-chip RAM.
- On command, streams the buffered image out in raster order as a valid/ready pixel stream with x/y coordinates and frame markers.
- Sits on the 100 MHz fabric clock and feeds downstream processing or display logic.
- It is the write-side counterpart of the capture-and-read path.

---
 rtl/image_writer_if.sv | 30 +++
 rtl/image_writer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/image_writer_if.sv
// Bus bundle for image_writer: Avalon-MM register port plus the outgoing
// valid/ready pixel stream. The slave modport is the writer's view, the
// master modport is the view of the host and the downstream sink.
interface image_writer_if #(
  parameter int PIX_W = 8
);
  logic [1:0]       addr;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic [10:0]      out_x;
  logic [10:0]      out_y;
  logic             out_sof;
  logic             out_eol;
  logic             done;

  modport slave (
    input  addr, rd_en, wr_en, writedata, out_ready,
    output readdata, out_valid, out_pixel, out_x, out_y, out_sof, out_eol, done
  );

  modport master (
    output addr, rd_en, wr_en, writedata, out_ready,
    input  readdata, out_valid, out_pixel, out_x, out_y, out_sof, out_eol, done
  );
endinterface

// File: rtl/image_writer.sv
// image_writer: the HPS fills an on-chip image buffer four pixels per Avalon
// write; a START command then streams the image out in raster order as a
// valid/ready pixel stream with x/y coordinates and frame markers.
// Optional macro IMAGE_WRITER_LOOP_EN enables control bit2 LOOP, which
// restarts the frame back-to-back instead of returning to IDLE.
module image_writer #(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224,
  parameter int PIX_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  image_writer_if.slave  bus
);
  localparam int N     = IMG_W * IMG_H;
  localparam int AW    = $clog2(N + 1);
  localparam int WORDS = N / 4;
  localparam int WA    = $clog2(WORDS);
  localparam logic [AW-1:0] N_PTR  = AW'(N);
  localparam logic [10:0]   X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0]   Y_LAST = 11'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic            r_overflow, r_err;
  logic [15:0]     r_frames;
  logic            r_done;
  logic [31:0]     r_mem [WORDS];
  logic [31:0]     r_word;
  logic [1:0]      r_sel;
  logic            r_valid;
  logic [10:0]     r_ox, r_oy;
  logic [10:0]     r_fx, r_fy;
  logic [AW-1:0]   r_fidx;
  logic            r_fdone;
  logic            w_loop;

  // Register-port decode
  logic w_wr_data, w_wr_ctrl, w_wr_ptr, w_clear, w_start_req, w_start_ok;
  logic w_full, w_data_ok, w_beat, w_last_acc, w_f_last, w_load;
  logic [31:0]   w_ptr_req;
  logic [AW-1:0] w_ptr_clamped;

  assign w_wr_data   = bus.wr_en && (bus.addr == 2'd0);
  assign w_wr_ctrl   = bus.wr_en && (bus.addr == 2'd1);
  assign w_wr_ptr    = bus.wr_en && (bus.addr == 2'd3);
  assign w_clear     = w_wr_ctrl && bus.writedata[1];
  assign w_start_req = w_wr_ctrl && bus.writedata[0] && !w_clear;
  assign w_full      = (r_wr_ptr == N_PTR);
  assign w_start_ok  = w_start_req && (r_state == IDLE) && w_full;
  assign w_data_ok   = reset_n && w_wr_data && (r_state == IDLE) && !w_full;
  assign w_ptr_req   = {bus.writedata[31:2], 2'b00};
  assign w_ptr_clamped = (w_ptr_req > 32'(N)) ? N_PTR : w_ptr_req[AW-1:0];

  // Stream handshake: the output register doubles as the RAM read register,
  // so a new word is fetched exactly when the held beat empties or moves on.
  assign w_beat     = r_valid && bus.out_ready;
  assign w_last_acc = w_beat && (r_ox == X_LAST) && (r_oy == Y_LAST);
  assign w_f_last   = (r_fx == X_LAST) && (r_fy == Y_LAST);
  // Once the last pixel is fetched, only LOOP allows wrapping to (0,0); that
  // fetch coincides with acceptance of the last beat, so LOOP is judged then.
  assign w_load     = reset_n && (r_state == STREAM) && (!r_valid || bus.out_ready) &&
                      (!r_fdone || w_loop) && !w_clear;

`ifdef IMAGE_WRITER_LOOP_EN
  logic r_loop;
  // LOOP control bit, rewritten by every control write
  always_ff @(posedge clk) begin
    if (!reset_n)       r_loop <= 1'b0;
    else if (w_wr_ctrl) r_loop <= bus.writedata[2];
  end
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; CLEAR overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) w_state_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (w_start_ok) w_state_nxt = STREAM;
        STREAM:  if (w_last_acc && !w_loop) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Write pointer and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset_n || w_clear) begin
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr_data) begin
        if (r_state != IDLE) r_err      <= 1'b1;
        else if (w_full)     r_overflow <= 1'b1;
        else                 r_wr_ptr   <= r_wr_ptr + AW'(4);
      end
      if (w_start_req && !w_start_ok) r_err <= 1'b1;
      if (w_wr_ptr && (r_state == IDLE)) r_wr_ptr <= w_ptr_clamped;
    end
  end

  // Frame completion pulse and frame counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_done   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_done <= w_last_acc && !w_clear;
      if (r_done) r_frames <= r_frames + 16'd1;
    end
  end

  // Image RAM, one word per four pixels, with registered read into r_word
  always_ff @(posedge clk) begin
    if (w_data_ok) r_mem[WA'(r_wr_ptr >> 2)] <= bus.writedata;
    if (w_load)    r_word <= r_mem[WA'(r_fidx >> 2)];
  end

  // Fetch counters and output beat registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_sel   <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_fidx  <= '0;
      r_fdone <= 1'b0;
    end else if (w_clear) begin
      r_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_fx    <= '0;
      r_fy    <= '0;
      r_fidx  <= '0;
      r_fdone <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ox    <= r_fx;
      r_oy    <= r_fy;
      r_sel   <= r_fidx[1:0];
      if (w_f_last) begin
        r_fx    <= '0;
        r_fy    <= '0;
        r_fidx  <= '0;
        r_fdone <= 1'b1;
      end else begin
        r_fdone <= 1'b0;
        r_fidx  <= r_fidx + AW'(1);
        if (r_fx == X_LAST) begin
          r_fx <= '0;
          r_fy <= r_fy + 11'd1;
        end else begin
          r_fx <= r_fx + 11'd1;
        end
      end
    end else if (w_beat) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_pixel = r_valid ? r_word[int'(r_sel)*PIX_W +: PIX_W] : '0;
  assign bus.out_x     = r_ox;
  assign bus.out_y     = r_oy;
  assign bus.out_sof   = r_valid && (r_ox == 11'd0) && (r_oy == 11'd0);
  assign bus.out_eol   = r_valid && (r_ox == X_LAST);
  assign bus.done      = r_done;

  // Combinational register read-back
  always_comb begin
    bus.readdata = '0;
    if (bus.rd_en) begin
      case (bus.addr)
        2'd1:    bus.readdata = {29'b0, w_loop, 2'b0};
        2'd2:    bus.readdata = {r_frames, 11'b0, r_err, r_overflow, w_full, r_state};
        2'd3:    bus.readdata = 32'(r_wr_ptr);
        default: bus.readdata = '0;
      endcase
    end
  end
endmodule
